// File: rtl/spart_bus_if_buffered.sv
// Host bus interface for the SPART block: register decode, RX/TX FIFOs,
// transmit launcher, sticky error flags and double-buffered baud divisor.
module spart_bus_if_buffered #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned BAUD_RST = 325
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iocs,
    input  logic                  iorw,
    input  logic [1:0]            ioaddr,
    inout  wire  [DATA_W-1:0]     databus,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [DATA_W-1:0]     tx_data,
    output logic [2*DATA_W-1:0]   baud_div,
    output logic                  baud_load
);

    localparam int unsigned RXA = $clog2(RX_DEPTH);
    localparam int unsigned TXA = $clog2(TX_DEPTH);
    localparam int unsigned BW  = 2 * DATA_W;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] status;

    assign rd_en = iocs && iorw;
    assign wr_en = iocs && !iorw;

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RXA-1:0]    rx_wp_q, rx_wp_d;
    logic [RXA-1:0]    rx_rp_q, rx_rp_d;
    logic [RXA:0]      rx_cnt_q, rx_cnt_d;
    logic              rx_empty, rx_full;
    logic              rx_pop, rx_push, rx_drop;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (RXA+1)'(RX_DEPTH));
    assign rx_pop   = rd_en && (ioaddr == 2'b00) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign rx_drop  = rx_valid && !rx_push;

    always_comb begin
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_wp_d = rx_wp_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rp_d = rx_rp_q + 1'b1;
        end
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wp_q] <= rx_data;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TXA-1:0]    tx_wp_q, tx_wp_d;
    logic [TXA-1:0]    tx_rp_q, tx_rp_d;
    logic [TXA:0]      tx_cnt_q, tx_cnt_d;
    logic              tx_empty, tx_full;
    logic              tx_pop, tx_push_req, tx_push, tx_drop;

    assign tx_empty    = (tx_cnt_q == '0);
    assign tx_full     = (tx_cnt_q == (TXA+1)'(TX_DEPTH));
    assign tx_push_req = wr_en && (ioaddr == 2'b00);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop     = tx_push_req && !tx_push;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_wp_d = tx_wp_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rp_d = tx_rp_q + 1'b1;
        end
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wp_q] <= databus;
        end
    end

    // ---------------- TX launcher ----------------
    state_e            state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    always_comb begin
        state_d    = state_q;
        tx_pop     = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty && tx_ready) begin
                    tx_pop     = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_mem_q[tx_rp_q];
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- flags and baud ----------------
    logic              rx_ovr_q, rx_ovr_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              flag_clr;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic              baud_load_q, baud_load_d;
    logic              baud_commit;

    assign flag_clr    = wr_en && (ioaddr == 2'b01);
    assign baud_commit = wr_en && (ioaddr == 2'b11);

    // A new error in the clearing cycle keeps the flag set.
    always_comb begin
        rx_ovr_d    = rx_drop || (rx_ovr_q && !(flag_clr && databus[2]));
        tx_ovf_d    = tx_drop || (tx_ovf_q && !(flag_clr && databus[3]));
        shadow_d    = shadow_q;
        baud_d      = baud_q;
        baud_load_d = baud_commit;
        if (wr_en && (ioaddr == 2'b10)) begin
            shadow_d = databus;
        end
        if (baud_commit) begin
            baud_d = {databus, shadow_q};
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            state_q     <= S_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            shadow_q    <= '0;
            baud_q      <= BW'(BAUD_RST);
            baud_load_q <= 1'b0;
        end else begin
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ovf_q    <= tx_ovf_d;
            shadow_q    <= shadow_d;
            baud_q      <= baud_d;
            baud_load_q <= baud_load_d;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] occ32;
    logic [3:0]  occ_sat;

    assign occ32   = 32'(rx_cnt_q);
    assign occ_sat = (occ32 > 32'd15) ? 4'hF : occ32[3:0];

    always_comb begin
        status      = '0;
        status[0]   = !rx_empty;
        status[1]   = !tx_full;
        status[2]   = rx_ovr_q;
        status[3]   = tx_ovf_q;
        status[7:4] = occ_sat;
    end

    always_comb begin
        rd_data = '0;
        unique case (ioaddr)
            2'b00: begin
                if (!rx_empty) begin
                    rd_data = rx_mem_q[rx_rp_q];
                end
            end
            2'b01:   rd_data = status;
            2'b10:   rd_data = baud_q[DATA_W-1:0];
            2'b11:   rd_data = baud_q[BW-1:DATA_W];
            default: rd_data = '0;
        endcase
    end

    assign databus   = (rd_en && !rst) ? rd_data : {DATA_W{1'bz}};
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign baud_div  = baud_q;
    assign baud_load = baud_load_q;

endmodule

// File: tb/tb_spart_bus_if_buffered.sv
// Directed bench for spart_bus_if_buffered: vector table for RX/status
// traffic, hand-written sequences for baud, TX drain and reset mid-launch.
module tb_spart_bus_if_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic [7:0]  drv;
    logic        drv_en;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] baud_div;
    logic        baud_load;

    int checks = 0;
    int errors = 0;

    assign databus = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    spart_bus_if_buffered #(
        .DATA_W   (8),
        .RX_DEPTH (8),
        .TX_DEPTH (8),
        .BAUD_RST (325)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .baud_div  (baud_div),
        .baud_load (baud_load)
    );

    typedef struct {
        bit       cs;
        bit       rw;
        bit [1:0] addr;
        bit [7:0] wd;
        bit       rxv;
        bit [7:0] rxd;
        bit       chk;
        bit [7:0] exp;
        string    name;
    } vec_t;

    vec_t rows[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = 2'b00;
        drv_en   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = a;
        drv    = d;
        drv_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e,
                      input string nm);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = a;
        drv_en = 1'b0;
        @(negedge clk);
        chk(nm, databus, e);
        tick();
        idle();
    endtask

    task automatic add(input bit cs, input bit rw, input bit [1:0] a,
                       input bit [7:0] wd, input bit rxv,
                       input bit [7:0] rxd, input bit c,
                       input bit [7:0] e, input string n);
        vec_t v;
        v.cs   = cs;
        v.rw   = rw;
        v.addr = a;
        v.wd   = wd;
        v.rxv  = rxv;
        v.rxd  = rxd;
        v.chk  = c;
        v.exp  = e;
        v.name = n;
        rows.push_back(v);
    endtask

    initial begin
        int  n;
        int  last;
        int  pulses;
        bit  st;
        bit  seen;

        // reset, with the bench driving the bus during a read request
        rst      = 1'b1;
        iocs     = 1'b1;
        iorw     = 1'b1;
        ioaddr   = 2'b01;
        drv      = 8'h5A;
        drv_en   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("bus_hiz_in_rst", databus, 8'h5A);
        tick();
        tick();
        rst = 1'b0;
        idle();

        chk("rst_baud_div", baud_div, 16'd325);
        chk("rst_baud_load", baud_load, 1'b0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        rd(2'b01, 8'h02, "rst_status");

        // baud divisor double buffering
        wr(2'b10, 8'hA2);
        chk("baud_low_only", baud_div, 16'd325);
        chk("baud_no_load", baud_load, 1'b0);
        wr(2'b11, 8'h01);
        chk("baud_commit", baud_div, 16'h01A2);
        chk("baud_load_pulse", baud_load, 1'b1);
        tick();
        chk("baud_load_end", baud_load, 1'b0);
        rd(2'b10, 8'hA2, "baud_rd_lo");
        rd(2'b11, 8'h01, "baud_rd_hi");

        // RX vector table
        for (int i = 0; i < 9; i++)
            add(0, 0, 2'b00, 8'h00, 1, 8'(8'h10 + i), 0, 8'h00, "rx_fill");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h87, "st_overrun");
        for (int i = 0; i < 8; i++)
            add(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'(8'h10 + i), "rx_pop");
        add(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'h00, "rx_empty_rd");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h06, "st_empty");
        add(1, 0, 2'b01, 8'h04, 0, 8'h00, 0, 8'h00, "clr_ovr");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h02, "st_cleared");
        for (int i = 0; i < 8; i++)
            add(0, 0, 2'b00, 8'h00, 1, 8'(8'h20 + i), 0, 8'h00, "rx_refill");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h83, "st_full");
        add(1, 1, 2'b00, 8'h00, 1, 8'h28, 1, 8'h20, "full_pop_push");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h83, "st_full_kept");
        for (int i = 1; i < 9; i++)
            add(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'(8'h20 + i), "rx_drain");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h02, "st_drained");
        add(1, 1, 2'b00, 8'h00, 1, 8'h33, 1, 8'h00, "empty_rd_push");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h13, "st_one");
        add(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'h33, "rx_kept");
        add(1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h02, "st_final");

        foreach (rows[i]) begin
            iocs     = rows[i].cs;
            iorw     = rows[i].rw;
            ioaddr   = rows[i].addr;
            drv      = rows[i].wd;
            drv_en   = rows[i].cs && !rows[i].rw;
            rx_valid = rows[i].rxv;
            rx_data  = rows[i].rxd;
            @(negedge clk);
            if (rows[i].chk)
                chk(rows[i].name, databus, rows[i].exp);
            tick();
        end
        idle();

        // TX overflow then drain with a transmitter model
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            wr(2'b00, 8'(8'h41 + i));
        rd(2'b01, 8'h08, "tx_full_status");
        n    = 0;
        last = -10;
        tx_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            st = tx_start;
            if (st) begin
                if (n < 9)
                    chk("tx_data", tx_data, 8'(8'h41 + n));
                if (n > 0)
                    chk("tx_spacing", (c - last) >= 2, 1'b1);
                last = c;
                n++;
            end
            tick();
            tx_ready = !st;
        end
        chk("tx_count", n, 8);
        chk("tx_data_hold", tx_data, 8'h48);
        rd(2'b01, 8'h0A, "tx_drained_status");
        wr(2'b01, 8'h08);
        rd(2'b01, 8'h02, "tx_ovf_cleared");

        // reset during HOLD with entries still queued
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            wr(2'b00, 8'(8'h51 + i));
        tx_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (tx_start)
                seen = 1'b1;
            else
                tick();
        end
        chk("launch_seen", seen, 1'b1);
        chk("launch_data", tx_data, 8'h51);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_tx_start", tx_start, 1'b0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_start)
                pulses++;
            tick();
        end
        chk("no_launch_after_rst", pulses, 0);
        rd(2'b01, 8'h02, "mid_rst_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spart_bus_if_buffered.md
# spart_bus_if_buffered

- Parametrised host-side bus interface for the SPART serial block.
- Sits between the processor's `iocs`/`iorw`/`ioaddr`/`databus` port and the SPART transmitter, receiver and baud generator.
- Adds a receive FIFO and a transmit FIFO, with a self-draining transmit launcher and sticky overrun/overflow flags.
- The baud divisor is held in a register loaded atomically by a low/high write pair; the data width is generic.

## Interface
Parameters:
- `DATA_W`, 8 — databus width; must be ≥ 8.
- `RX_DEPTH`, 8 — receive FIFO entries; power of two, ≥ 2.
- `TX_DEPTH`, 8 — transmit FIFO entries; power of two, ≥ 2.
- `BAUD_RST`, 325 — divisor value after reset, width 2*DATA_W.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1 — the single clock.
  - `rst` input 1 — synchronous, active-high reset.
- Host bus:
  - `iocs` input 1 — chip select; every cycle it is high is one access.
  - `iorw` input 1 — 1 = read, 0 = write.
  - `ioaddr` input 2 — register select.
  - `databus` inout DATA_W — shared bus, driven only while `iocs && iorw`.
- Receiver side:
  - `rx_valid` input 1 — one-cycle strobe: received character on `rx_data`.
  - `rx_data` input DATA_W — received character.
- Transmitter side:
  - `tx_ready` input 1 — transmitter idle and able to accept a character.
  - `tx_start` output 1 — one-cycle launch strobe.
  - `tx_data` output DATA_W — character to send; valid with `tx_start`.
- Baud generator:
  - `baud_div` output 2*DATA_W — current divisor.
  - `baud_load` output 1 — one-cycle strobe when `baud_div` changes.

## Operation
Register map (read / write):
- `00`: read pops the RX head; write pushes `databus` into the TX FIFO.
- `01`: read returns status. Write clears the sticky flags, write-1-to-clear (bit2 and bit3 only).
- `10`: read returns `baud_div[DATA_W-1:0]`. Write stores `databus` into a low shadow register; `baud_div` is unchanged.
- `11`: read returns `baud_div[2*DATA_W-1:DATA_W]`. Write commits `{databus, shadow}` to `baud_div` and pulses `baud_load`.

Status word:
- bit0 `rda`: RX FIFO not empty.
- bit1 `tbr`: TX FIFO not full.
- bit2 `rx_overrun`.
- bit3 `tx_overflow`.
- bits [7:4]: RX occupancy, saturated at 15.
- bits [DATA_W-1:8]: 0.

Read data:
- Combinational from the current FIFO head, status or divisor; no wait states.
- RX read while empty returns 0: no pop, no flag.

RX FIFO:
- Push when `rx_valid` and (not full, or an RX pop occurs in the same cycle).
- A push otherwise is dropped and sets `rx_overrun`.
- Push and pop in the same cycle on an empty FIFO: the read returns 0 and the push is kept.

TX FIFO:
- Host push when (not full, or a launcher pop occurs in the same cycle).
- A push otherwise is dropped and sets `tx_overflow`.

FIFO mechanics:
- Circular buffers with read and write pointers that wrap modulo depth.
- Occupancy counters are clog2(depth)+1 bits wide.

Sticky flags:
- A clear and a new set in the same cycle: the set wins.

TX launcher FSM:
- IDLE: if TX FIFO not empty and `tx_ready`, then at the edge set `tx_start`=1, set `tx_data`=head, pop, and go to HOLD.
- HOLD: `tx_start`=0, return to IDLE at the next edge.
- `tx_data` holds the last launched value until the next launch.

## Timing
- Reset values:
  - FIFOs empty, pointers 0, flags 0, shadow 0.
  - `tx_start`=0, `tx_data`=0.
  - `baud_div`=BAUD_RST, `baud_load`=0, FSM in IDLE.
- Reset mid-operation discards all buffered data and any pending launch in one edge.
- `databus` drive:
  - Drives `databus` combinationally in the same cycle that `iocs && iorw`.
  - High-Z otherwise, including during `rst`.
- Write timing:
  - A host write is sampled at the `clk` edge.
  - The status reflects it from the next cycle.
- Pop timing:
  - An RX pop takes effect at the edge ending the read cycle.
  - The next read sees the next entry.
- RX receive latency: `rx_valid` at edge N → `rda`=1 from cycle N+1.
- TX launch latency:
  - Host write at edge N → earliest `tx_start` high in cycle N+1 to N+2.
  - Successive launches are spaced ≥ 2 cycles apart.
- Transmitter contract: `tx_ready` must be low in the cycle after `tx_start` is high.
- Baud timing:
  - `baud_div` updates at the edge of the `11` write.
  - `baud_load` is high for exactly the following cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `baud_div`=325, status=0x02, `tx_start`=0, `databus` high-Z.
- **RX fill:**
  - Pulse `rx_valid` 9× with data 0x10..0x18 at depth 8 → status bit2=1 and occupancy 8.
  - Eight `00` reads return 0x10..0x17; a ninth read returns 0 with bit0=0.
  - Writing 0x04 to `01` clears bit2.
- **TX drain:**
  - Hold `tx_ready`=0 and write 0x41..0x49 (9×) → bit1=0 and bit3=1.
  - Drive `tx_ready` high (dropped for one cycle after each launch) → `tx_start` pulses 8× with 0x41..0x48, each pulse ≥ 2 cycles apart.
- **Baud load:**
  - Write 0xA2 to `10` → `baud_div` still 325.
  - Write 0x01 to `11` → `baud_div`=0x01A2 and `baud_load` high for one cycle.
  - Reads of `10`/`11` return 0xA2/0x01.
- **Simultaneous events:**
  - RX full + `rx_valid` during a `00` read → read returns the head, the push is kept, occupancy stays 8, no overrun.
  - Empty RX + read + `rx_valid` → read returns 0, occupancy becomes 1.
- **Reset mid-launch:** `rst` in the HOLD cycle with 3 TX entries pending → next cycle TX FIFO empty, no further `tx_start`.
